mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_dma_pkg.sv | 6 +
 rtl/mem_copy_engine.sv | 96 +++++++++
 tb/tb_mem_copy_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared state encoding and copy-direction constants for the memory copy engine.
package mem_dma_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
   localparam logic DIR_B2U = 1'b0;
   localparam logic DIR_U2B = 1'b1;
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words between BRAM and URAM, overlapping one read and one write per cycle.
module mem_copy_engine
   import mem_dma_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          ps_clk,
   input  logic          rst_ni,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_dir_i,
   input  logic [AW-1:0] cmd_src_i,
   input  logic [AW-1:0] cmd_dst_i,
   input  logic [AW-1:0] cmd_len_i,
   input  logic          abort_i,
   output logic          bmem_en_o,
   output logic          bmem_we_o,
   output logic [AW-1:0] bmem_addr_o,
   output logic [DW-1:0] bmem_wdt_o,
   input  logic [DW-1:0] bmem_rdt_i,
   output logic          umem_en_o,
   output logic          umem_we_o,
   output logic [AW-1:0] umem_addr_o,
   output logic [DW-1:0] umem_wdt_o,
   input  logic [DW-1:0] umem_rdt_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          aborted_o,
   output logic [AW-1:0] wcnt_o
);
   localparam logic [AW-1:0] ONE = AW'(1);
   state_e        state_q, state_d;
   logic          dir_q, wv_q, err_q, abt_q;
   logic [AW-1:0] src_q, dst_q, wa_q, rem_q, wcnt_q;
   logic          hs, rd, b_src;
   assign hs    = cmd_valid_i && state_q == IDLE;
   assign rd    = state_q == READ;
   assign b_src = dir_q == DIR_B2U;
   always_comb begin
      state_d = (state_q == IDLE)  ? ((hs && cmd_len_i != '0) ? READ : IDLE) :
                (state_q == READ)  ? ((rem_q == ONE || abort_i) ? DRAIN : READ) :
                (state_q == DRAIN) ? DONE : IDLE;
   end
   // wa_q/wv_q hold the destination slot of the read issued last cycle; its data arrives now
   always_ff @(posedge ps_clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         dir_q   <= DIR_B2U;
         wv_q    <= 1'b0;
         err_q   <= 1'b0;
         abt_q   <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         wa_q    <= '0;
         rem_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wv_q    <= rd;
         err_q   <= hs && cmd_len_i == '0;
         if (hs) begin
            dir_q  <= cmd_dir_i;
            src_q  <= cmd_src_i;
            dst_q  <= cmd_dst_i;
            rem_q  <= cmd_len_i;
            abt_q  <= 1'b0;
            wcnt_q <= '0;
         end else begin
            if (rd) begin
               src_q <= src_q + ONE;
               dst_q <= dst_q + ONE;
               wa_q  <= dst_q;
               rem_q <= rem_q - ONE;
               if (abort_i) abt_q <= 1'b1;
            end
            if (wv_q) wcnt_q <= wcnt_q + ONE;
         end
      end
   end
   assign bmem_en_o   = b_src ? rd : wv_q;
   assign bmem_we_o   = !b_src && wv_q;
   assign bmem_addr_o = (b_src && rd) ? src_q : (!b_src && wv_q) ? wa_q : '0;
   assign bmem_wdt_o  = (!b_src && wv_q) ? umem_rdt_i : '0;
   assign umem_en_o   = b_src ? wv_q : rd;
   assign umem_we_o   = b_src && wv_q;
   assign umem_addr_o = (!b_src && rd) ? src_q : (b_src && wv_q) ? wa_q : '0;
   assign umem_wdt_o  = (b_src && wv_q) ? bmem_rdt_i : '0;
   assign cmd_ready_o = state_q == IDLE;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
   assign err_o       = err_q;
   assign aborted_o   = abt_q && state_q == DONE;
   assign wcnt_o      = wcnt_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed scenarios against behavioural BRAM/URAM models with hand-computed results.
module tb_mem_copy_engine;
   localparam int AW = 8;
   localparam int DW = 32;
   logic          ps_clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_dir_i = 1'b0, abort_i = 1'b0;
   logic [AW-1:0] cmd_src_i = '0, cmd_dst_i = '0, cmd_len_i = '0;
   logic          bmem_en_o, bmem_we_o, umem_en_o, umem_we_o;
   logic [AW-1:0] bmem_addr_o, umem_addr_o, wcnt_o;
   logic [DW-1:0] bmem_wdt_o, umem_wdt_o, bmem_rdt_i, umem_rdt_i;
   logic          busy_o, done_o, err_o, aborted_o;
   logic          load = 1'b1;
   logic [DW-1:0] bram [0:255];
   logic [DW-1:0] uram [0:255];
   int            nw_tot = 0, nen_tot = 0, nerr_tot = 0;
   int            checks = 0, passes = 0;

   mem_copy_engine #(.AW(AW), .DW(DW)) dut (
      .ps_clk(ps_clk), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dir_i(cmd_dir_i),
      .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_len_i(cmd_len_i), .abort_i(abort_i),
      .bmem_en_o(bmem_en_o), .bmem_we_o(bmem_we_o), .bmem_addr_o(bmem_addr_o),
      .bmem_wdt_o(bmem_wdt_o), .bmem_rdt_i(bmem_rdt_i),
      .umem_en_o(umem_en_o), .umem_we_o(umem_we_o), .umem_addr_o(umem_addr_o),
      .umem_wdt_o(umem_wdt_o), .umem_rdt_i(umem_rdt_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .aborted_o(aborted_o), .wcnt_o(wcnt_o)
   );

   always #5 ps_clk = ~ps_clk;

   // single-port memories: read data appears the cycle after an enabled read
   always @(posedge ps_clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) begin
            bram[i] <= DW'(i);
            uram[i] <= DW'(i);
         end
      end else begin
         if (bmem_en_o) begin
            if (bmem_we_o) bram[bmem_addr_o] <= bmem_wdt_o;
            else bmem_rdt_i <= bram[bmem_addr_o];
         end
         if (umem_en_o) begin
            if (umem_we_o) uram[umem_addr_o] <= umem_wdt_o;
            else umem_rdt_i <= uram[umem_addr_o];
         end
      end
      if ((bmem_en_o && bmem_we_o) || (umem_en_o && umem_we_o)) nw_tot <= nw_tot + 1;
      if (bmem_en_o || umem_en_o) nen_tot <= nen_tot + 1;
      if (err_o) nerr_tot <= nerr_tot + 1;
   end

   task automatic run_cmd(input logic d, input logic [AW-1:0] s, input logic [AW-1:0] t,
                          input logic [AW-1:0] l, input int ab, output int dn,
                          output logic [AW-1:0] wc, output logic ab_o, output logic bz, output int nw);
      int base;
      @(negedge ps_clk);
      cmd_dir_i = d; cmd_src_i = s; cmd_dst_i = t; cmd_len_i = l; cmd_valid_i = 1'b1;
      base = nw_tot;
      @(posedge ps_clk);
      @(negedge ps_clk);
      cmd_valid_i = 1'b0;
      bz = busy_o;
      dn = 0; wc = '0; ab_o = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         abort_i = (n == ab);
         if (done_o) begin
            dn = n; wc = wcnt_o; ab_o = aborted_o;
            break;
         end
         @(negedge ps_clk);
      end
      abort_i = 1'b0;
      nw = nw_tot - base;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge ps_clk);
      checks++; if ({busy_o, done_o, err_o, aborted_o} !== 4'b0) $display("FAIL reset_status got %b want 0000", {busy_o, done_o, err_o, aborted_o}); else passes++;
      checks++; if ({bmem_en_o, bmem_we_o, umem_en_o, umem_we_o} !== 4'b0) $display("FAIL reset_en got %b want 0000", {bmem_en_o, bmem_we_o, umem_en_o, umem_we_o}); else passes++;
      checks++; if ({bmem_addr_o, umem_addr_o, wcnt_o} !== '0) $display("FAIL reset_addr_wcnt got %h %h %h want 0", bmem_addr_o, umem_addr_o, wcnt_o); else passes++;
      checks++; if ({bmem_wdt_o, umem_wdt_o} !== '0) $display("FAIL reset_wdt got %h %h want 0", bmem_wdt_o, umem_wdt_o); else passes++;
      rst_ni = 1'b1;
      load = 1'b0;
      @(negedge ps_clk);
      checks++; if (cmd_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready_o); else passes++;
   endtask

   task automatic test_b2u();
      int dn, nw; logic [AW-1:0] wc; logic ab_o, bz;
      run_cmd(1'b0, 8'd0, 8'd10, 8'd10, 0, dn, wc, ab_o, bz, nw);
      checks++; if (dn !== 12) $display("FAIL b2u_done_cycle got %0d want 12", dn); else passes++;
      checks++; if (wc !== 8'd10) $display("FAIL b2u_wcnt got %0d want 10", wc); else passes++;
      checks++; if (ab_o !== 1'b0) $display("FAIL b2u_aborted got %b want 0", ab_o); else passes++;
      checks++; if (bz !== 1'b1) $display("FAIL b2u_busy got %b want 1", bz); else passes++;
      checks++; if (nw !== 10) $display("FAIL b2u_writes got %0d want 10", nw); else passes++;
      for (int i = 0; i < 10; i++) begin
         checks++; if (uram[10+i] !== DW'(i)) $display("FAIL b2u_data uram[%0d] got %0d want %0d", 10+i, uram[10+i], i); else passes++;
      end
      checks++; if (uram[20] !== DW'(20)) $display("FAIL b2u_overrun uram[20] got %0d want 20", uram[20]); else passes++;
   endtask

   task automatic test_u2b();
      int dn, nw; logic [AW-1:0] wc; logic ab_o, bz;
      run_cmd(1'b1, 8'd10, 8'd20, 8'd10, 0, dn, wc, ab_o, bz, nw);
      checks++; if (dn !== 12) $display("FAIL u2b_done_cycle got %0d want 12", dn); else passes++;
      checks++; if (wc !== 8'd10) $display("FAIL u2b_wcnt got %0d want 10", wc); else passes++;
      for (int i = 0; i < 10; i++) begin
         checks++; if (bram[20+i] !== DW'(i)) $display("FAIL u2b_data bram[%0d] got %0d want %0d", 20+i, bram[20+i], i); else passes++;
      end
      for (int i = 0; i < 20; i++) begin
         checks++; if (bram[i] !== DW'(i)) $display("FAIL u2b_untouched bram[%0d] got %0d want %0d", i, bram[i], i); else passes++;
      end
   endtask

   task automatic test_wrap();
      int dn, nw, e0; logic [AW-1:0] wc; logic ab_o, bz;
      logic [DW-1:0] exp_w [0:9] = '{250, 251, 252, 253, 254, 255, 0, 1, 2, 3};
      e0 = nerr_tot;
      run_cmd(1'b0, 8'd250, 8'd0, 8'd10, 0, dn, wc, ab_o, bz, nw);
      checks++; if (dn !== 12) $display("FAIL wrap_done_cycle got %0d want 12", dn); else passes++;
      checks++; if (nerr_tot - e0 !== 0) $display("FAIL wrap_err got %0d pulses want 0", nerr_tot - e0); else passes++;
      for (int i = 0; i < 10; i++) begin
         checks++; if (uram[i] !== exp_w[i]) $display("FAIL wrap_data uram[%0d] got %0d want %0d", i, uram[i], exp_w[i]); else passes++;
      end
   endtask

   task automatic test_len0();
      int en0, e0;
      @(negedge ps_clk);
      cmd_dir_i = 1'b0; cmd_src_i = 8'd5; cmd_dst_i = 8'd6; cmd_len_i = 8'd0; cmd_valid_i = 1'b1;
      en0 = nen_tot; e0 = nerr_tot;
      @(negedge ps_clk);
      cmd_valid_i = 1'b0;
      checks++; if (err_o !== 1'b1) $display("FAIL len0_err got %b want 1", err_o); else passes++;
      checks++; if ({cmd_ready_o, busy_o} !== 2'b10) $display("FAIL len0_idle got ready=%b busy=%b want 1 0", cmd_ready_o, busy_o); else passes++;
      @(negedge ps_clk);
      checks++; if (err_o !== 1'b0) $display("FAIL len0_err_pulse got %b want 0", err_o); else passes++;
      repeat (2) @(negedge ps_clk);
      checks++; if (nen_tot - en0 !== 0) $display("FAIL len0_no_access got %0d enables want 0", nen_tot - en0); else passes++;
      checks++; if (nerr_tot - e0 !== 1) $display("FAIL len0_err_count got %0d want 1", nerr_tot - e0); else passes++;
   endtask

   task automatic test_abort();
      int dn, nw; logic [AW-1:0] wc; logic ab_o, bz;
      run_cmd(1'b0, 8'd30, 8'd100, 8'd20, 5, dn, wc, ab_o, bz, nw);
      checks++; if (dn !== 7) $display("FAIL abort_done_cycle got %0d want 7", dn); else passes++;
      checks++; if (nw !== 5) $display("FAIL abort_writes got %0d want 5", nw); else passes++;
      checks++; if (wc !== 8'd5) $display("FAIL abort_wcnt got %0d want 5", wc); else passes++;
      checks++; if (ab_o !== 1'b1) $display("FAIL abort_flag got %b want 1", ab_o); else passes++;
      for (int i = 0; i < 5; i++) begin
         checks++; if (uram[100+i] !== DW'(30+i)) $display("FAIL abort_data uram[%0d] got %0d want %0d", 100+i, uram[100+i], 30+i); else passes++;
      end
      checks++; if (uram[105] !== DW'(105)) $display("FAIL abort_extra uram[105] got %0d want 105", uram[105]); else passes++;
   endtask

   task automatic test_reset_mid();
      int dn, nw, base, k; logic [AW-1:0] wc; logic ab_o, bz;
      @(negedge ps_clk);
      cmd_dir_i = 1'b1; cmd_src_i = 8'd40; cmd_dst_i = 8'd150; cmd_len_i = 8'd20; cmd_valid_i = 1'b1;
      base = nw_tot;
      @(negedge ps_clk);
      cmd_valid_i = 1'b0;
      k = 0;
      while (nw_tot - base < 3 && k < 50) begin
         @(negedge ps_clk);
         k++;
      end
      checks++; if (nw_tot - base !== 3) $display("FAIL midrst_progress got %0d writes want 3", nw_tot - base); else passes++;
      rst_ni = 1'b0;
      #1;
      checks++; if ({busy_o, done_o, err_o, aborted_o, bmem_en_o, bmem_we_o, umem_en_o, umem_we_o} !== 8'b0) $display("FAIL midrst_outputs got %b want 0", {busy_o, done_o, err_o, aborted_o, bmem_en_o, bmem_we_o, umem_en_o, umem_we_o}); else passes++;
      checks++; if ({bmem_addr_o, umem_addr_o, wcnt_o, bmem_wdt_o, umem_wdt_o} !== '0) $display("FAIL midrst_data got %h %h %h want 0", bmem_addr_o, umem_addr_o, wcnt_o); else passes++;
      @(negedge ps_clk);
      rst_ni = 1'b1;
      @(negedge ps_clk);
      checks++; if (cmd_ready_o !== 1'b1) $display("FAIL midrst_ready got %b want 1", cmd_ready_o); else passes++;
      checks++; if (bram[153] !== DW'(153)) $display("FAIL midrst_pending bram[153] got %0d want 153", bram[153]); else passes++;
      checks++; if (bram[152] !== DW'(42)) $display("FAIL midrst_written bram[152] got %0d want 42", bram[152]); else passes++;
      run_cmd(1'b0, 8'd60, 8'd200, 8'd4, 0, dn, wc, ab_o, bz, nw);
      checks++; if (dn !== 6) $display("FAIL post_rst_done_cycle got %0d want 6", dn); else passes++;
      checks++; if (wc !== 8'd4) $display("FAIL post_rst_wcnt got %0d want 4", wc); else passes++;
      for (int i = 0; i < 4; i++) begin
         checks++; if (uram[200+i] !== DW'(60+i)) $display("FAIL post_rst_data uram[%0d] got %0d want %0d", 200+i, uram[200+i], 60+i); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_b2u();
      test_u2b();
      test_wrap();
      test_len0();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
